imem_boot_loader: RTL and testbench

//  Upstream of the single-cycle MIPS top: fills instruction memory from a byte

---
 rtl/imem_boot_loader.sv | 138 +++++++++++++
 tb/tb_imem_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length-prefixed byte stream into 32-bit imem writes and holds the
// CPU in reset until the whole image is written.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int unsigned Depth = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StDone, StError} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              we_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              err_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       shift_q;

  logic            take;
  logic [15:0]     len_full;
  logic [ADDR_W:0] wcnt_inc;

  assign in_ready   = in_ready_q & ~reset;
  assign take       = in_valid & in_ready;
  assign len_full   = {len_hi_q, in_data};
  assign wcnt_inc   = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLenHi;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StLenHi: begin
          in_ready_q <= 1'b1;
          if (take) begin
            len_hi_q <= in_data;
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (take) begin
            if (len_full == 16'd0) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else if ({16'd0, len_full} > Depth) begin
              state_q    <= StError;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= StData;
              len_q   <= len_full[ADDR_W:0];
            end
          end
        end
        StData: begin
          // Final strobe cycle: stop accepting, release the CPU only once it retires.
          if (last_q) begin
            state_q     <= StDone;
            last_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (take) begin
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= wcnt_q[ADDR_W-1:0];
              wdata_q <= {shift_q, in_data};
              wcnt_q  <= wcnt_inc;
              if (wcnt_inc == len_q) begin
                last_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end else begin
              shift_q <= {shift_q[15:0], in_data};
            end
          end
        end
        StDone, StError: begin
          if (restart) begin
            state_q     <= StLenHi;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
          end
        end
        default: state_q <= StLenHi;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: writes are predicted by parsing the byte stream
// directly and compared with the strobes captured from the DUT.
module tb_imem_boot_loader;

  localparam int unsigned AW = 8;
  localparam int DepthW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;

  imem_boot_loader #(.ADDR_W(AW), .WORD_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: cycle counter, captured write strobes, protocol invariants.
  int          cyc = 0;
  logic [7:0]  got_a[$];
  logic [31:0] got_d[$];
  int          viol = 0;
  int          done_rise = -1;
  int          last_we = -1;
  int          acc_cyc = -1;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_a.push_back(imem_addr);
      got_d.push_back(imem_wdata);
      last_we = cyc;
      if (cpu_reset !== 1'b1) viol++;
    end
    if ((done === 1'b1 || err === 1'b1) && in_ready === 1'b1) viol++;
    if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    done_prev = done;
  end

  logic [7:0]  stream[$];
  logic [7:0]  exp_a[$];
  logic [31:0] exp_d[$];

  task automatic send_byte(input logic [7:0] b, input int tmo, output bit acc);
    int t;
    t = 0;
    acc = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    while (!acc && t < tmo) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart(input bit do_chk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    if (do_chk) begin
      @(negedge clk);
      check_eq("rst_cpu_reset", cpu_reset, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mk_stream(input int n);
    logic [31:0] w;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
  endtask

  // Feed `stream`, predict writes from it, then check results and timing.
  task automatic do_load(input int gap_lo, input int gap_hi, input int restart_at);
    int  n;
    int  last_acc;
    bit  acc;
    bit  exp_err;
    exp_a.delete();
    exp_d.delete();
    got_a.delete();
    got_d.delete();
    viol = 0;
    done_rise = -1;
    last_we = -1;
    last_acc = -1;
    n = (int'(stream[0]) << 8) | int'(stream[1]);
    exp_err = (n > DepthW);
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        exp_a.push_back(k[7:0]);
        exp_d.push_back({stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
      end
    end
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], 50, acc);
      if (!acc) begin
        check_eq("byte_timeout", i, -1);
        break;
      end
      last_acc = acc_cyc;
      if (i == 1 && n > 0 && !exp_err) check_eq("cpu_reset_loading", cpu_reset, 1);
      if (i == restart_at) pulse_restart(1'b0);
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        @(posedge clk);
        #1;
      end
    end
    for (int t = 0; t < 20 && !(done === 1'b1 || err === 1'b1); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("nwrites", got_a.size(), exp_a.size());
    for (int k = 0; k < got_a.size() && k < exp_a.size(); k++) begin
      check_eq("waddr", got_a[k], exp_a[k]);
      check_eq("wdata", got_d[k], exp_d[k]);
    end
    check_eq("done", done, !exp_err);
    check_eq("err", err, exp_err);
    check_eq("cpu_reset_end", cpu_reset, exp_err);
    check_eq("in_ready_end", in_ready, 0);
    check_eq("invariants", viol, 0);
    if (!exp_err) begin
      if (n == 0) begin
        check_eq("lat_len0", done_rise - last_acc, 1);
      end else begin
        check_eq("lat_we_to_done", done_rise - last_we, 1);
        check_eq("lat_byte_to_done", done_rise - last_acc, 2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    restart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_in_ready", in_ready, 0);
    check_eq("reset_we", imem_we, 0);
    check_eq("reset_addr", imem_addr, 0);
    check_eq("reset_wdata", imem_wdata, 0);
    check_eq("reset_cpu_reset", cpu_reset, 1);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", in_ready, 0);
    @(posedge clk);
    #1;

    // Reference program, back-to-back bytes.
    stream = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
               8'h01, 8'h09, 8'h50, 8'h20};
    do_load(0, 0, -1);
    if (got_d.size() == 3) begin
      check_eq("prog_w0", got_d[0], 32'h20080005);
      check_eq("prog_w1", got_d[1], 32'h20090007);
      check_eq("prog_w2", got_d[2], 32'h01095020);
    end

    // Same stream with alternate-cycle gaps and an ignored mid-load restart.
    pulse_restart(1'b1);
    do_load(1, 1, 5);

    // Empty image.
    pulse_restart(1'b1);
    stream = '{8'h00, 8'h00};
    do_load(0, 0, -1);

    // Oversized length, then recovery.
    pulse_restart(1'b1);
    stream = '{8'h01, 8'h01};
    do_load(0, 0, -1);
    send_byte(8'hAA, 5, acc);
    check_eq("err_no_accept", acc, 0);
    pulse_restart(1'b1);
    mk_stream(1);
    do_load(0, 2, -1);

    // Reset in the middle of a load.
    pulse_restart(1'b1);
    mk_stream(2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 50, acc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_in_ready", in_ready, 0);
    check_eq("mid_we", imem_we, 0);
    check_eq("mid_addr", imem_addr, 0);
    check_eq("mid_wdata", imem_wdata, 0);
    check_eq("mid_cpu_reset", cpu_reset, 1);
    check_eq("mid_done", done, 0);
    check_eq("mid_err", err, 0);
    @(posedge clk);
    #1;
    mk_stream(2);
    do_load(0, 0, -1);

    // Reload after DONE.
    pulse_restart(1'b1);
    stream = '{8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h0A};
    do_load(0, 0, -1);

    // Random lengths and gaps.
    for (int r = 0; r < 6; r++) begin
      pulse_restart(1'b1);
      mk_stream($urandom_range(8, 1));
      do_load(0, $urandom_range(3, 0), -1);
    end

    // Full-depth image: last address is DEPTH-1.
    pulse_restart(1'b1);
    mk_stream(DepthW);
    do_load(0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
